note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Parametrised, programmable successor to the fixed-song note table.
//  A writable song table of DEPTH entries holds {note, length} pairs.
//  Playback is self-timed from a tempo strobe (beat): each entry is held for length+1 beats.
//  Features: start/stop, pause, one-shot or loop playback, programmable song end.
//  Sits between the control/keypad logic and the tone generator, which consumes note/length.
// PARAMETERS
//  NOTE_W  4   note code width; code 0 = rest
//  LEN_W   2   length code width; an entry lasts length+1 beats
//  DEPTH   64  song table entries; power of 2; localparam ADDR_W = $clog2(DEPTH)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  wr_en        in   1       table write strobe; honoured only when playing=0
//  wr_addr      in   ADDR_W  table write address
//  wr_note      in   NOTE_W  note code to write
//  wr_len       in   LEN_W   length code to write
//  last_idx     in   ADDR_W  index of final entry; sampled on accepted start
//  loop         in   1       1 = wrap to entry 0 after last_idx; sampled on accepted start
//  start        in   1       begin playback from entry 0; ignored while playing=1
//  stop         in   1       abort playback; has priority over start and beat
//  pause        in   1       level; while 1 in HOLD, beats are not counted
//  beat         in   1       one-cycle tempo strobe
//  note         out  NOTE_W  current note code; 0 (rest) when idle
//  length       out  LEN_W   current length code
//  note_strobe  out  1       one-cycle pulse on each note/length update
//  pos          out  ADDR_W  index of the entry currently presented
//  playing      out  1       1 in FETCH or HOLD
//  done         out  1       one-cycle pulse when one-shot playback completes
// BEHAVIOUR
//  Reset: state=IDLE; note=0, length=0, pos=0, note_strobe=0, playing=0, done=0.
//  Reset also clears beats_left, last_idx_q and loop_q. Table contents are not reset.
//  Table: combinational read at pos; synchronous write. wr_en while playing=1 is dropped.
//  FSM states:
//   IDLE:
//    - start && !stop: last_idx_q<=last_idx, loop_q<=loop, pos<=0, go to FETCH.
//   FETCH (one cycle):
//    - note<=tbl[pos].note, length<=tbl[pos].len, beats_left<=len+1 (LEN_W+1 bits).
//    - note_strobe<=1, go to HOLD. A beat arriving in FETCH is not counted.
//   HOLD:
//    - beat && !pause: beats_left-=1.
//    - On the beat that takes beats_left from 1 to 0:
//      - pos!=last_idx_q: pos<=pos+1, go to FETCH.
//      - pos==last_idx_q && loop_q: pos<=0, go to FETCH.
//      - pos==last_idx_q && !loop_q: go to IDLE, note<=0, done<=1.
//  Latency: start at edge k -> note/note_strobe valid after edge k+2.
//  Latency: final beat of an entry at edge k -> next entry visible after edge k+2.
//  stop in FETCH/HOLD: next edge -> IDLE, note<=0, length<=0, no done pulse.
//  stop in IDLE has no effect.
//  last_idx=0 plays a single entry. pos never exceeds last_idx_q.
//  ADDR_W wrap is impossible.
//  Async reset mid-playback: immediate return to reset values. Table retains its data.
// TESTING
//  1. Write {1,0},{2,1},{4,3}; last_idx=2, loop=0; start; beat every 4 clk.
//     -> notes 1,2,4 held 1,2,4 beats; note_strobe x3; done once; note=0.
//  2. Same table with loop=1; run 10 beats.
//     -> sequence 1,2,2,4,4,4,4,1,2,2 by beat; done never asserts.
//  3. Hold pause=1 for 5 beats mid-entry 1.
//     -> note stays 2; beats_left unchanged; resumes correctly after pause drops.
//  4. stop and beat asserted in the same cycle during HOLD.
//     -> IDLE next edge; note=0; done=0.
//  5. start while playing; wr_en to addr 0 while playing.
//     -> both ignored; replay after stop shows the original entry 0.
//  6. rst_n low for 1 cycle mid-HOLD.
//     -> all outputs at reset values immediately; restart plays the table unchanged.
//  7. last_idx=0, loop=0, entry {7,0}; start.
//     -> note=7 for one beat; done pulses; note=0.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: programmable song table with beat-timed playback.
// Holds DEPTH {note, length} entries; each entry is presented for length+1
// beats. Supports start/stop, pause, one-shot or looped playback and a
// programmable final entry. Feeds note/length to the tone generator.
module note_sequencer #(
  parameter int NOTE_W = 4,
  parameter int LEN_W  = 2,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              beat,
  output logic [NOTE_W-1:0] note,
  output logic [LEN_W-1:0]  length,
  output logic              note_strobe,
  output logic [ADDR_W-1:0] pos,
  output logic              playing,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Song table storage; contents survive reset on purpose so a song can be
  // replayed after a reset without reloading it.
  logic [NOTE_W-1:0] tbl_note [DEPTH];
  logic [LEN_W-1:0]  tbl_len  [DEPTH];

  state_t            state_reg, state_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic [LEN_W-1:0]  length_reg, length_next;
  logic              strobe_reg, strobe_next;
  logic [ADDR_W-1:0] pos_reg, pos_next;
  logic              done_reg, done_next;
  logic [LEN_W:0]    beats_left_reg, beats_left_next;
  logic [ADDR_W-1:0] last_idx_reg, last_idx_next;
  logic              loop_reg, loop_next;

  // Combinational read of the entry currently addressed by pos.
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0]  rd_len;
  assign rd_note = tbl_note[pos_reg];
  assign rd_len  = tbl_len[pos_reg];

  assign playing     = (state_reg != ST_IDLE);
  assign note        = note_reg;
  assign length      = length_reg;
  assign note_strobe = strobe_reg;
  assign pos         = pos_reg;
  assign done        = done_reg;

  // Table write port; writes during playback are dropped so the entry being
  // played can never change underneath the sequencer.
  always_ff @(posedge clk) begin
    if (wr_en && !playing) begin
      tbl_note[wr_addr] <= wr_note;
      tbl_len[wr_addr]  <= wr_len;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      note_reg       <= '0;
      length_reg     <= '0;
      strobe_reg     <= 1'b0;
      pos_reg        <= '0;
      done_reg       <= 1'b0;
      beats_left_reg <= '0;
      last_idx_reg   <= '0;
      loop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      note_reg       <= note_next;
      length_reg     <= length_next;
      strobe_reg     <= strobe_next;
      pos_reg        <= pos_next;
      done_reg       <= done_next;
      beats_left_reg <= beats_left_next;
      last_idx_reg   <= last_idx_next;
      loop_reg       <= loop_next;
    end
  end

  // Next-state logic; stop overrides start and beat in every playing state.
  always_comb begin
    state_next      = state_reg;
    note_next       = note_reg;
    length_next     = length_reg;
    strobe_next     = 1'b0;
    pos_next        = pos_reg;
    done_next       = 1'b0;
    beats_left_next = beats_left_reg;
    last_idx_next   = last_idx_reg;
    loop_next       = loop_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          last_idx_next = last_idx;
          loop_next     = loop;
          pos_next      = '0;
          state_next    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (stop) begin
          state_next  = ST_IDLE;
          note_next   = '0;
          length_next = '0;
        end else begin
          // A beat landing here is deliberately ignored; the entry's full
          // duration starts counting from HOLD.
          note_next       = rd_note;
          length_next     = rd_len;
          beats_left_next = (LEN_W+1)'(rd_len) + (LEN_W+1)'(1);
          strobe_next     = 1'b1;
          state_next      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (stop) begin
          state_next  = ST_IDLE;
          note_next   = '0;
          length_next = '0;
        end else if (beat && !pause) begin
          beats_left_next = beats_left_reg - (LEN_W+1)'(1);
          if (beats_left_reg == (LEN_W+1)'(1)) begin
            if (pos_reg != last_idx_reg) begin
              pos_next   = pos_reg + ADDR_W'(1);
              state_next = ST_FETCH;
            end else if (loop_reg) begin
              pos_next   = '0;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_IDLE;
              note_next  = '0;
              done_next  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
